mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named clock and reset.
REQ-002 Port list, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26], taken from the instruction register
- mem_ready  in  1  memory access completes in this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 1=MDR
- RegDst  out  1  destination register select: 1=rd, 0=rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=read_data_1
- ALUSrcB  out  2  00=read_data_2, 01=constant 4, 10=immEx, 11=immEx<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  3  ALU operation
- illegal  out  1  sticky flag: unsupported opcode seen
- instr_count  out  32  count of retired instructions

Function
REQ-003 States: START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP.
REQ-004 Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
REQ-005 ALUOp encoding: ADD=3'b010, SUB=3'b110, RTYPE=3'b000 (downstream decodes funct).
REQ-006 Every output not listed for a state SHALL be 0 in that state.
REQ-007 START: all outputs 0; next state FETCH.
REQ-008 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
- IRWrite=PCWrite=1 only in the cycle where mem_ready=1; the FSM then moves to DECODE.
- Otherwise the FSM holds in FETCH.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD. Next state by opcode:
- lw/sw -> MEMADR
- R -> EXEC
- beq -> BRANCH
- j -> JUMP
- addi -> ADDIEX
- any other opcode -> TRAP
REQ-010 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state MEMRD for lw, MEMWR for sw.
REQ-011 MEMRD: MemRead=1, IorD=1; holds until mem_ready=1, then MEMWB.
REQ-012 MEMWR: MemWrite=1, IorD=1; holds until mem_ready=1, then FETCH; this is the last cycle of sw.
REQ-013 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-014 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE; next state RWB.
REQ-015 RWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01; next state FETCH.
REQ-017 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-018 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; next state ADDIWB.
REQ-019 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-020 TRAP: all outputs 0 except illegal=1; held until reset.
REQ-021 Cycle counts with mem_ready=1 on the first request cycle:
- lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
REQ-022 mem_ready SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.
REQ-023 instr_count SHALL increment by 1 on the clock edge that leaves the last state of an instruction: MEMWB, MEMWR (on ready), RWB, BRANCH, JUMP or ADDIWB.
REQ-024 instr_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-025 illegal SHALL be set on the edge that enters TRAP; instr_count SHALL NOT increment for the trapping instruction.
REQ-026 opcode SHALL be sampled only in DECODE and MEMADR; changes in other states have no effect.

Reset
REQ-027 While reset=0, state=START, instr_count=0, illegal=0, and all outputs SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 Reset asserted in any state, including mid-wait in MEMRD/MEMWR, SHALL abort the instruction with no further writes.
REQ-029 The first rising edge after reset release SHALL move the FSM START->FETCH.

Structure
REQ-030 Package mips_ctrl_pkg SHALL hold the state encoding (4-bit), opcode constants, ALUOp constants, and ALUSrcB/PCSource encodings.
REQ-031 A single combinational sub-module, mips_ctrl_outdec, SHALL map (state, mem_ready) to all control outputs; the sequential logic (state register, counter, illegal flag) SHALL sit in mips_multicycle_ctrl.

Verification
REQ-032 Release reset, mem_ready=1, opcode=100011 (lw) -> states START,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; instr_count=1 after MEMWB.
REQ-033 sw with mem_ready=0 for 3 MEMWR cycles -> MemWrite=1 and IorD=1 for 4 cycles, instruction takes 7 cycles total, RegWrite never 1.
REQ-034 Sequence R, beq, j, addi with mem_ready=1 -> cycles 4,3,3,4; PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP; instr_count=4.
REQ-035 opcode=111111 at DECODE -> TRAP, illegal=1, all outputs 0 for 20 cycles, instr_count unchanged; reset clears both.
REQ-036 reset=0 asynchronously mid-MEMRD with mem_ready=0 -> MemRead drops before the next edge; after release, START then FETCH.
REQ-037 Preload instr_count=32'hFFFFFFFF by forcing, then retire j -> instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

  // 4-bit FSM state encoding
  localparam logic [3:0] ST_START  = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_RWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;
  localparam logic [3:0] ST_ADDIEX = 4'd11;
  localparam logic [3:0] ST_ADDIWB = 4'd12;
  localparam logic [3:0] ST_TRAP   = 4'd13;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b000;

  // ALU B operand select
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bundle of all datapath control lines
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational output decoder: (state, mem_ready) -> control lines.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control word; anything not set stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALU_RTYPE;
      end
      ST_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RD2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, retire counter, illegal flag.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUOp,
  output logic        illegal,
  output logic [31:0] instr_count
);

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic        retire;
  logic        illegal_q;
  logic [31:0] instr_cnt_q;
  ctrl_t       ctrl;

  // Next-state logic; opcode is only looked at in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_START;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_START;
    else        state_q <= state_d;
  end

  // Retired-instruction counter; holds unless an instruction completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      instr_cnt_q <= '0;
    else if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
  end

  // Sticky illegal flag, set on the edge entering TRAP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                            illegal_q <= 1'b0;
    else if (state_q == ST_DECODE && state_d == ST_TRAP)   illegal_q <= 1'b1;
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Drive ports from the decoded control word
  always_comb begin
    PCWrite     = ctrl.pc_write;
    PCWriteCond = ctrl.pc_write_cond;
    IorD        = ctrl.iord;
    MemRead     = ctrl.mem_read;
    MemWrite    = ctrl.mem_write;
    IRWrite     = ctrl.ir_write;
    MemtoReg    = ctrl.mem_to_reg;
    RegDst      = ctrl.reg_dst;
    RegWrite    = ctrl.reg_write;
    ALUSrcA     = ctrl.alu_src_a;
    ALUSrcB     = ctrl.alu_src_b;
    PCSource    = ctrl.pc_source;
    ALUOp       = ctrl.alu_op;
    illegal     = illegal_q;
    instr_count = instr_cnt_q;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl with an instruction-level model.
module tb_mips_multicycle_ctrl;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [31:0] instr_count;

  int unsigned tests;
  int unsigned fails;
  logic [31:0] model_count;

  mips_multicycle_ctrl dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal(illegal), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed outputs in a fixed order
  typedef struct packed {
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic illegal;
  } obs_t;

  obs_t obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal};

  // Instruction phases as the reference model sees them
  typedef enum int { P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                     P_EXEC, P_RWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB, P_TRAP } phase_e;

  // Control word each phase must show, straight from the output table
  function automatic obs_t expect_of(phase_e p, logic rdy);
    obs_t e;
    e = '0;
    case (p)
      P_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 3'b010;
                      e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE: begin e.alu_src_b = 2'b11; e.alu_op = 3'b010; end
      P_MEMADR, P_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
      P_MEMRD:  begin e.mem_read = 1; e.iord = 1; end
      P_MEMWR:  begin e.mem_write = 1; e.iord = 1; end
      P_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      P_EXEC:   begin e.alu_src_a = 1; e.alu_op = 3'b000; end
      P_RWB:    begin e.reg_write = 1; e.reg_dst = 1; end
      P_BRANCH: begin e.alu_src_a = 1; e.alu_op = 3'b110; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      P_JUMP:   begin e.pc_write = 1; e.pc_source = 2'b10; end
      P_ADDIWB: begin e.reg_write = 1; end
      P_TRAP:   begin e.illegal = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH, checking every cycle; waits<0 means random
  task automatic drive_instr(input logic [5:0] op, input int fwait, input int mwait,
                             output int cycles, output int mw_cyc, output int rw_cyc);
    phase_e q[$];
    bit legal;
    int n;
    logic rdy;
    obs_t e;
    legal = 1;
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    case (op)
      6'b100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
      6'b101011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
      6'b000000: begin q.push_back(P_EXEC); q.push_back(P_RWB); end
      6'b000100: q.push_back(P_BRANCH);
      6'b000010: q.push_back(P_JUMP);
      6'b001000: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
      default: begin legal = 0; for (int t = 0; t < 20; t++) q.push_back(P_TRAP); end
    endcase
    cycles = 0; mw_cyc = 0; rw_cyc = 0;
    foreach (q[i]) begin
      n = 0;
      if (q[i] == P_FETCH)
        n = (fwait < 0) ? int'($urandom_range(0, 3)) : fwait;
      else if (q[i] == P_MEMRD || q[i] == P_MEMWR)
        n = (mwait < 0) ? int'($urandom_range(0, 3)) : mwait;
      for (int k = 0; k <= n; k++) begin
        if (q[i] == P_FETCH || q[i] == P_MEMRD || q[i] == P_MEMWR) rdy = (k == n);
        else rdy = 1'($urandom_range(0, 1));
        if (q[i] == P_DECODE || q[i] == P_MEMADR) opcode = op;
        else opcode = 6'($urandom);
        mem_ready = rdy;
        #1;
        e = expect_of(q[i], rdy);
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL ctrl op=%b phase=%s cyc=%0d: got %h want %h",
                   op, q[i].name(), cycles, obs, e);
        end
        if (MemWrite === 1'b1) mw_cyc++;
        if (RegWrite === 1'b1) rw_cyc++;
        cycles++;
        @(posedge clock); #1;
      end
    end
    if (legal) model_count = model_count + 32'd1;
    tests++;
    if (instr_count !== model_count) begin
      fails++;
      $display("FAIL instr_count op=%b: got %h want %h", op, instr_count, model_count);
    end
  endtask

  // Stimulus only: pulse reset and step through the START cycle into FETCH
  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b0; opcode = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    model_count = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
    #2;
    tests++;
    if (obs !== '0 || instr_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h cnt %h want 0 cnt 0", obs, instr_count);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL start_state: got %h want 0", obs);
    end
    @(posedge clock); #1;
    mem_ready = 1'b0;
    #1;
    tests++;
    if (obs !== expect_of(P_FETCH, 1'b0)) begin
      fails++;
      $display("FAIL first_fetch: got %h want %h", obs, expect_of(P_FETCH, 1'b0));
    end
    #1;
    model_count = '0;
  endtask

  task automatic test_lw();
    int c, mw, rw;
    drive_instr(6'b100011, 0, 0, c, mw, rw);
    tests++;
    if (c !== 5 || instr_count !== 32'd1) begin
      fails++;
      $display("FAIL lw_basic: got cycles %0d cnt %0d want 5 and 1", c, instr_count);
    end
  endtask

  task automatic test_sw_wait();
    int c, mw, rw;
    drive_instr(6'b101011, 0, 3, c, mw, rw);
    tests++;
    if (c !== 7 || mw !== 4 || rw !== 0) begin
      fails++;
      $display("FAIL sw_wait: got cycles %0d memwrite %0d regwrite %0d want 7 4 0", c, mw, rw);
    end
  endtask

  task automatic test_sequence();
    logic [5:0] ops [4];
    int exp_c [4];
    int c, mw, rw;
    ops = '{6'b000000, 6'b000100, 6'b000010, 6'b001000};
    exp_c = '{4, 3, 3, 4};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_instr(ops[i], 0, 0, c, mw, rw);
      tests++;
      if (c !== exp_c[i]) begin
        fails++;
        $display("FAIL seq_cycles[%0d]: got %0d want %0d", i, c, exp_c[i]);
      end
    end
    tests++;
    if (instr_count !== 32'd4) begin
      fails++;
      $display("FAIL seq_count: got %0d want 4", instr_count);
    end
  endtask

  // Random legal instructions with random memory wait states
  task automatic test_random();
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int fw, mwt, c, mw, rw, base;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    for (int i = 0; i < 40; i++) begin
      op  = legal_ops[$urandom_range(0, 5)];
      fw  = int'($urandom_range(0, 3));
      mwt = int'($urandom_range(0, 3));
      case (op)
        6'b100011: base = 5 + fw + mwt;
        6'b101011: base = 4 + fw + mwt;
        6'b000000, 6'b001000: base = 4 + fw;
        default: base = 3 + fw;
      endcase
      drive_instr(op, fw, mwt, c, mw, rw);
      tests++;
      if (c !== base) begin
        fails++;
        $display("FAIL rand_cycles op=%b: got %0d want %0d", op, c, base);
      end
    end
  endtask

  task automatic test_wrap();
    int c, mw, rw;
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    model_count = 32'hFFFF_FFFF;
    drive_instr(6'b000010, 0, 0, c, mw, rw);
    tests++;
    if (instr_count !== 32'd0) begin
      fails++;
      $display("FAIL wrap: got %h want 00000000", instr_count);
    end
  endtask

  task automatic test_async_reset();
    opcode = 6'b100011; mem_ready = 1'b1;
    @(posedge clock); #1;   // FETCH -> DECODE
    @(posedge clock); #1;   // DECODE -> MEMADR
    @(posedge clock); #1;   // MEMADR -> MEMRD
    mem_ready = 1'b0;
    #1;
    tests++;
    if (MemRead !== 1'b1 || IorD !== 1'b1) begin
      fails++;
      $display("FAIL memrd_wait: got MemRead %b IorD %b want 1 1", MemRead, IorD);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== '0 || instr_count !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: got %h cnt %h want 0 cnt 0", obs, instr_count);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL async_start: got %h want 0", obs);
    end
    @(posedge clock); #1;
    #1;
    tests++;
    if (obs !== expect_of(P_FETCH, 1'b0)) begin
      fails++;
      $display("FAIL async_fetch: got %h want %h", obs, expect_of(P_FETCH, 1'b0));
    end
    model_count = '0;
  endtask

  task automatic test_trap();
    int c, mw, rw;
    logic [5:0] op;
    drive_instr(6'b111111, 0, 0, c, mw, rw);
    reset = 1'b0;
    #1;
    tests++;
    if (illegal !== 1'b0 || instr_count !== 32'd0 || obs !== '0) begin
      fails++;
      $display("FAIL trap_clear: got illegal %b cnt %h obs %h want 0 0 0", illegal, instr_count, obs);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    model_count = '0;
    // A random unsupported opcode traps too
    do op = 6'($urandom);
    while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
    drive_instr(op, -1, 0, c, mw, rw);
    do_reset();
    drive_instr(6'b000010, -1, 0, c, mw, rw);
  endtask

  initial begin
    tests = 0; fails = 0; model_count = '0;
    reset = 1'b0; opcode = '0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_sequence();
    test_random();
    test_wrap();
    test_async_reset();
    test_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
